// File: rtl/bcd_seg_pkg.sv
// Shared definitions for the 3-digit BCD 7-segment scanner: scan state
// encodings, logical (active-high) segment patterns and small helpers.
package bcd_seg_pkg;

   typedef enum logic [1:0] {
      ST_ONES = 2'd0,
      ST_TENS = 2'd1,
      ST_HUND = 2'd2
   } scan_st_e;

   // Segment order {a,b,c,d,e,f,g}, bit 6 = a, logical active-high
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Digit enable for a scan state: bit0 ones, bit1 tens, bit2 hundreds
   function automatic logic [2:0] st_onehot(input scan_st_e st);
      logic [2:0] oh;
      oh = 3'b000;
      case (st)
         ST_ONES: oh = 3'b001;
         ST_TENS: oh = 3'b010;
         ST_HUND: oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // True when a packed BCD word holds any non-decimal nibble
   function automatic logic bcd_has_invalid(input logic [11:0] w);
      return (w[11:8] > 4'd9) || (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to 7-segment decoder (logical active-high).
// Nibbles above 9 render as a dash so bad converter output is visible.
module bcd_to_7seg
   import bcd_seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // Lookup of the decimal glyphs; everything else is a dash
   always_comb begin
      seg_o = SEG_DASH;
      case (nib_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 3-digit 7-segment driver fed by a packed BCD word.
// Optional leading-zero blanking is enabled by defining BCD_SEG_BLANK_EN.
//
// state   | meaning
// --------+-------------------------------------------
// ST_ONES | ones digit selected (an bit0), reset state
// ST_TENS | tens digit selected (an bit1)
// ST_HUND | hundreds digit selected (an bit2)
//
// Outputs are registered from the current state and shadow value, so an
// and seg always switch together on the same edge.
module bcd_seg_scan
   import bcd_seg_pkg::*;
#(
   parameter int SCAN_DIV    = 1000,
   parameter bit SEG_ACT_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] bcd_in,
   input  logic        load,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic        digit_err
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [6:0]       SEG_POL  = {7{SEG_ACT_LOW}};
   localparam logic [2:0]       AN_POL   = {3{SEG_ACT_LOW}};

   logic [DIV_W-1:0] div_q, div_d;
   scan_st_e         st_q, st_d;
   logic [11:0]      val_q, val_d;
   logic             err_q, err_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;

   logic             tick;
   logic [3:0]       nib_sel;
   logic [6:0]       dec_seg;
   logic             blank;

   assign tick = (div_q == DIV_LAST);

   // Prescaler: free-running 0..SCAN_DIV-1, terminal count is the scan tick
   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (tick) begin
         div_d = '0;
      end
   end

   // Scan FSM next state: rotate ones -> tens -> hundreds on each tick
   always_comb begin
      st_d = st_q;
      if (tick) begin
         case (st_q)
            ST_ONES: st_d = ST_TENS;
            ST_TENS: st_d = ST_HUND;
            ST_HUND: st_d = ST_ONES;
            default: st_d = ST_ONES;
         endcase
      end
   end

   // Shadow register and error flag follow the load strobe only
   always_comb begin
      val_d = val_q;
      err_d = err_q;
      if (load) begin
         val_d = bcd_in;
         err_d = bcd_has_invalid(bcd_in);
      end
   end

   // Select the nibble of the currently enabled digit
   always_comb begin
      nib_sel = val_q[3:0];
      case (st_q)
         ST_ONES: nib_sel = val_q[3:0];
         ST_TENS: nib_sel = val_q[7:4];
         ST_HUND: nib_sel = val_q[11:8];
         default: nib_sel = val_q[3:0];
      endcase
   end

   bcd_to_7seg u_dec (
      .nib_i (nib_sel),
      .seg_o (dec_seg)
   );

`ifdef BCD_SEG_BLANK_EN
   // Leading-zero blanking; an invalid hundreds nibble counts as non-zero
   always_comb begin
      blank = 1'b0;
      case (st_q)
         ST_HUND: blank = (val_q[11:8] == 4'd0);
         ST_TENS: blank = (val_q[11:8] == 4'd0) && (val_q[7:4] == 4'd0);
         default: blank = 1'b0;
      endcase
   end
`else
   // All digits always decoded, leading zeros included
   always_comb begin
      blank = 1'b0;
   end
`endif

   // Output register inputs, polarity applied here for common-anode boards
   always_comb begin
      seg_d = (blank ? SEG_BLANK : dec_seg) ^ SEG_POL;
      an_d  = st_onehot(st_q) ^ AN_POL;
   end

   // State, shadow and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         st_q  <= ST_ONES;
         val_q <= 12'h000;
         err_q <= 1'b0;
         seg_q <= SEG_BLANK ^ SEG_POL;
         an_q  <= 3'b000 ^ AN_POL;
      end else begin
         div_q <= div_d;
         st_q  <= st_d;
         val_q <= val_d;
         err_q <= err_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign digit_err = err_q;

endmodule
